setpoint_controller: RTL
========================

// Module: setpoint_controller
// PURPOSE
//  Operator front-end that sets the values driven into the 7-segment display controller and the PWM datapath.
//  Three push-buttons (up, down, mode) are synchronised, debounced and edge-detected.
//  A small FSM applies one saturating step per press.
//  Outputs: mode select, frequency code (30..200 kHz) and current code (10..100 %), plus a change strobe.
// PARAMETERS
//  DB_LIMIT   500000  consecutive stable cycles before a button level is accepted (10 ms @ 50 MHz)
//  DB_CNT_W   20      width of each debounce counter; must hold DB_LIMIT-1
//  FREQ_INIT  3'd0    frequency code after reset (0 = 30 kHz)
//  CURR_INIT  4'd1    current code after reset (1 = 10 %)
// PORTS
//  clk_i       in   1  system clock
//  reset       in   1  asynchronous reset, active-high
//  btn_up_i    in   1  raw button, asynchronous, high = pressed
//  btn_down_i  in   1  raw button, asynchronous, high = pressed
//  btn_mode_i  in   1  raw button, asynchronous, high = pressed
//  modo_o      out  1  1 = frequency mode, 0 = current mode
//  valorf_o    out  3  frequency code 0..7 = 30,50,75,100,125,150,175,200 kHz
//  valorC_o    out  4  current code 1..10 = 10..100 %
//  cambio_o    out  1  one-cycle pulse when any output value changes
// BEHAVIOUR
//  Reset (async, active-high): clears all registers; all outputs take their reset values immediately.
//   - modo_o=1, valorf_o=FREQ_INIT, valorC_o=CURR_INIT, cambio_o=0
//   - sync flops=0, debounced levels=0, counters=0, FSM=IDLE
//  Per-button conditioning:
//   - 2-FF synchroniser.
//   - Counter clears while synced==debounced and increments while they differ.
//   - When the counter reaches DB_LIMIT-1 and still differs, the debounced level takes the synced value and the counter clears.
//   - press pulse = debounced rising edge, exactly 1 cycle wide.
//   - Raw edge to press pulse: 2 + DB_LIMIT + 1 cycles.
//   - Glitches shorter than DB_LIMIT cycles produce no pulse.
//  FSM:
//   - IDLE: on any press pulse, latch cmd and go to STEP. Same-cycle priority: mode > up > down; losers are discarded.
//   - STEP (1 cycle): apply cmd, register new outputs, assert cambio_o on the next cycle iff a value actually changed; go to HOLD.
//   - HOLD: stay until all three debounced levels are 0, then go to IDLE. Press pulses arriving in HOLD are ignored (no auto-repeat).
//  Latency: press pulse in cycle k -> STEP in k+1 -> new values and cambio_o visible in cycle k+2.
//  Commands:
//   - mode: toggle modo_o. Both codes are retained unchanged; cambio_o=1.
//   - up, modo_o=1: valorf_o+1, saturating at 7.
//   - up, modo_o=0: valorC_o+1, saturating at 10.
//   - down, modo_o=1: valorf_o-1, saturating at 0.
//   - down, modo_o=0: valorC_o-1, saturating at 1.
//   - A step blocked by saturation leaves the value unchanged and keeps cambio_o=0.
//  Invariants:
//   - valorC_o is never 0 and never above 10; valorf_o never wraps.
//   - Outputs change only in the cycle after STEP.
//  Reset mid-operation: returns immediately to the reset values. A button still held after reset release:
//   - is debounced as a fresh press and yields a pulse after DB_LIMIT cycles;
//   - that press is accepted (IDLE).
// STRUCTURE
//  Shared package:
//   - FSM state encodings (IDLE, STEP, HOLD)
//   - cmd encodings (NONE, MODE, UP, DOWN)
//   - FREQ_MAX=3'd7, CURR_MIN=4'd1, CURR_MAX=4'd10
//   - mode constants MODO_FREQ=1, MODO_CORR=0
//  Sub-module button_debounce (parameters DB_LIMIT, DB_CNT_W): sync + debounce + rise pulse; outputs level_o, press_o.
//   Instantiated three times.
//  The top level holds the FSM, the value registers and the cambio_o flop.
// TESTING (bench uses DB_LIMIT=4, DB_CNT_W=3)
//  1 Reset: assert reset mid-clock -> outputs 1/0/1/0 immediately, with no clock edge required.
//  2 Up held 10 cycles in mode 1 -> valorf_o 0->1, one cambio_o pulse exactly k+2 after press_o.
//    Release and repeat 8 times -> valorf_o stops at 7; the 8th press gives no cambio_o.
//  3 Mode press -> modo_o=0, valorC_o=1. Down press -> valorC_o stays 1, no cambio_o.
//    Then 12 up presses -> valorC_o saturates at 10.
//  4 Up pulse of 3 cycles (< DB_LIMIT) and bouncing input (toggle every 2 cycles, 20 cycles) -> no press, outputs unchanged.
//  5 Up and mode pressed in the same cycle -> only modo_o toggles; codes unchanged. A second up press during HOLD -> ignored.
//  6 Hold down, assert reset for 2 cycles, keep down held -> outputs at reset values.
//    Then valorf_o stays 0 (saturated down) with no cambio_o, and the FSM returns to IDLE only after release.

Source files
------------

// File: rtl/setpoint_controller_pkg.sv
// Shared types and constants for the operator setpoint front-end.
// FSM states, command codes, value limits and mode encodings.
package setpoint_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_MODE = 2'd1,
        CMD_UP   = 2'd2,
        CMD_DOWN = 2'd3
    } cmd_e;

    localparam logic [2:0] FREQ_MAX = 3'd7;
    localparam logic [3:0] CURR_MIN = 4'd1;
    localparam logic [3:0] CURR_MAX = 4'd10;

    localparam logic MODO_FREQ = 1'b1;
    localparam logic MODO_CORR = 1'b0;

    // Same-cycle presses resolve as mode > up > down.
    function automatic cmd_e pick_cmd(
        input logic mode,
        input logic up,
        input logic down
    );
        cmd_e c;
        if (mode)      c = CMD_MODE;
        else if (up)   c = CMD_UP;
        else if (down) c = CMD_DOWN;
        else           c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/setpoint_controller_button_debounce.sv
// Push-button conditioning: 2-FF synchroniser, counter debounce
// and a one-cycle pulse on the debounced rising edge.
module button_debounce #(
    parameter int DB_LIMIT = 500000,
    parameter int DB_CNT_W = 20
) (
    input  logic clk_i,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                level_q;
    logic                level_d;
    logic                prev_q;
    logic                press_q;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/setpoint_controller.sv
// Setpoint front-end: three debounced buttons drive a step FSM that
// updates mode, frequency code and current code with saturation.
module setpoint_controller
    import setpoint_controller_pkg::*;
#(
    parameter int         DB_LIMIT  = 500000,
    parameter int         DB_CNT_W  = 20,
    parameter logic [2:0] FREQ_INIT = 3'd0,
    parameter logic [3:0] CURR_INIT = 4'd1
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_mode_i,
    output logic       modo_o,
    output logic [2:0] valorf_o,
    output logic [3:0] valorC_o,
    output logic       cambio_o
);

    logic up_lvl;
    logic up_prs;
    logic dn_lvl;
    logic dn_prs;
    logic md_lvl;
    logic md_prs;

    button_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_CNT_W (DB_CNT_W)
    ) u_up (
        .clk_i   (clk_i),
        .reset   (reset),
        .btn_i   (btn_up_i),
        .level_o (up_lvl),
        .press_o (up_prs)
    );

    button_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_CNT_W (DB_CNT_W)
    ) u_down (
        .clk_i   (clk_i),
        .reset   (reset),
        .btn_i   (btn_down_i),
        .level_o (dn_lvl),
        .press_o (dn_prs)
    );

    button_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_CNT_W (DB_CNT_W)
    ) u_mode (
        .clk_i   (clk_i),
        .reset   (reset),
        .btn_i   (btn_mode_i),
        .level_o (md_lvl),
        .press_o (md_prs)
    );

    state_e     state_q;
    cmd_e       cmd_q;
    logic       modo_q;
    logic [2:0] valorf_q;
    logic [3:0] valorC_q;
    logic       cambio_q;

    logic any_press;
    logic any_level;

    assign any_press = up_prs | dn_prs | md_prs;
    assign any_level = up_lvl | dn_lvl | md_lvl;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_NONE;
            modo_q   <= MODO_FREQ;
            valorf_q <= FREQ_INIT;
            valorC_q <= CURR_INIT;
            cambio_q <= 1'b0;
        end else begin
            cambio_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_press) begin
                        cmd_q   <= pick_cmd(md_prs, up_prs, dn_prs);
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    case (cmd_q)
                        CMD_MODE: begin
                            modo_q   <= ~modo_q;
                            cambio_q <= 1'b1;
                        end
                        CMD_UP: begin
                            if (modo_q == MODO_FREQ) begin
                                if (valorf_q < FREQ_MAX) begin
                                    valorf_q <= valorf_q + 3'd1;
                                    cambio_q <= 1'b1;
                                end
                            end else if (valorC_q < CURR_MAX) begin
                                valorC_q <= valorC_q + 4'd1;
                                cambio_q <= 1'b1;
                            end
                        end
                        CMD_DOWN: begin
                            if (modo_q == MODO_FREQ) begin
                                if (valorf_q > 3'd0) begin
                                    valorf_q <= valorf_q - 3'd1;
                                    cambio_q <= 1'b1;
                                end
                            end else if (valorC_q > CURR_MIN) begin
                                valorC_q <= valorC_q - 4'd1;
                                cambio_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    state_q <= ST_HOLD;
                end
                // No auto-repeat: wait for every button to be released.
                ST_HOLD: begin
                    if (!any_level) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign modo_o   = modo_q;
    assign valorf_o = valorf_q;
    assign valorC_o = valorC_q;
    assign cambio_o = cambio_q;

endmodule
